// File: rtl/serial_ram_loader_if.sv
// Loader-to-RAM bundle: serial input side plus RAM write port and status.
// master drives start/sin/sin_valid; slave (the loader) drives the RAM and status outputs.
interface serial_ram_loader_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             start;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] ram_in;
    logic             ram_load;
    logic [AW-1:0]    ram_address;
    logic             busy;
    logic             done;

    modport master (
        output start, sin, sin_valid,
        input  ram_in, ram_load, ram_address, busy, done
    );

    modport slave (
        input  start, sin, sin_valid,
        output ram_in, ram_load, ram_address, busy, done
    );
endinterface

// File: rtl/serial_ram_loader.sv
// Bit-serial RAM preloader: MSB-first words into addresses 0..DEPTH-1, 17 cycles per word.
// sin_valid=0 stalls shifting; bits offered during the one-cycle WRITE are dropped.
module serial_ram_loader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    serial_ram_loader_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_ram_in;
    logic [BW-1:0]    r_bit_cnt;
    logic [AW-1:0]    r_word_cnt;
    logic             r_ram_load;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_last_bit;
    logic             w_last_word;

    assign w_shreg_nxt = {r_shreg[WIDTH-2:0], bus.sin};
    assign w_last_bit  = (r_bit_cnt == BW'(WIDTH - 1));
    assign w_last_word = (r_word_cnt == AW'(DEPTH - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_ram_in   <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_ram_load <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ram_load <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_SHIFT;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (bus.sin_valid) begin
                        r_shreg <= w_shreg_nxt;
                        if (w_last_bit) begin
                            // Outputs for WRITE are set here so they are registered for that cycle.
                            r_bit_cnt  <= '0;
                            r_state    <= S_WRITE;
                            r_ram_load <= 1'b1;
                            r_ram_in   <= w_shreg_nxt;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_word) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_in      = r_ram_in;
    assign bus.ram_load    = r_ram_load;
    assign bus.ram_address = r_word_cnt;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_serial_ram_loader.sv
// Directed bench: an 8-word loader and a 1-word loader share the serial stream;
// expected RAM writes are queued by stimulus and checked by per-DUT monitors.
module tb_serial_ram_loader;
    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start8 = 1'b0;
    logic start1 = 1'b0;
    logic sin = 1'b0;
    logic sin_valid = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int e0 = 0;
    int done_cnt8 = 0;
    int done_edge8 = -1;
    logic prev_load8 = 1'b0;
    logic prev_load1 = 1'b0;

    exp_t q8[$];
    exp_t q1[$];
    logic [15:0] mem8 [8];
    logic [15:0] wv [8];

    serial_ram_loader_if #(.WIDTH(16), .AW(3)) if8 ();
    serial_ram_loader_if #(.WIDTH(16), .AW(3)) if1 ();

    assign if8.start     = start8;
    assign if8.sin       = sin;
    assign if8.sin_valid = sin_valid;
    assign if1.start     = start1;
    assign if1.sin       = sin;
    assign if1.sin_valid = sin_valid;

    serial_ram_loader #(.WIDTH(16), .DEPTH(8), .AW(3)) u8 (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (if8.slave)
    );

    serial_ram_loader #(.WIDTH(16), .DEPTH(1), .AW(3)) u1 (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (if1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // RAM8 model fed by the 8-word loader.
    always @(posedge clk) begin
        if (if8.ram_load) mem8[if8.ram_address] <= if8.ram_in;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if8.ram_load) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write8: addr %0d data %h with no write expected", if8.ram_address, if8.ram_in);
            end else begin
                e = q8.pop_front();
                chk("wr8_addr", 32'(if8.ram_address), 32'(e.a));
                chk("wr8_data", 32'(if8.ram_in), 32'(e.d));
            end
            chk("wr8_one_cycle", 32'(prev_load8), 32'd0);
        end
        prev_load8 = if8.ram_load;
        if (if8.done) begin
            done_cnt8++;
            done_edge8 = cyc - e0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if1.ram_load) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write1: addr %0d data %h with no write expected", if1.ram_address, if1.ram_in);
            end else begin
                e = q1.pop_front();
                chk("wr1_addr", 32'(if1.ram_address), 32'(e.a));
                chk("wr1_data", 32'(if1.ram_in), 32'(e.d));
            end
            chk("wr1_one_cycle", 32'(prev_load1), 32'd0);
        end
        prev_load1 = if1.ram_load;
    end

    // Called at a negedge; returns at the negedge after the WRITE cycle ends.
    task automatic send_word(input logic [15:0] w, input bit stall, input bit junk,
                             input bit pulse, input bit busy_chk);
        for (int i = 15; i >= 0; i--) begin
            if (stall) begin
                int ns = $urandom_range(0, 2);
                for (int s = 0; s < ns; s++) begin
                    sin_valid = 1'b0;
                    sin = 1'($urandom);
                    @(negedge clk);
                    if (busy_chk) chk("busy_stall", 32'(if8.busy), 32'd1);
                end
            end
            sin = w[i];
            sin_valid = 1'b1;
            start8 = (pulse && i == 10);
            @(negedge clk);
            if (busy_chk) chk("busy_stall", 32'(if8.busy), 32'd1);
        end
        start8 = pulse;
        sin_valid = junk;
        sin = 1'b1;
        @(negedge clk);
        if (busy_chk) chk("busy_write", 32'(if8.busy), 32'd1);
        start8 = 1'b0;
        sin_valid = 1'b0;
    endtask

    task automatic begin_run8();
        done_cnt8 = 0;
        done_edge8 = -1;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        e0 = cyc;
    endtask

    // Full 8-word run of wv[]; ends at the negedge after the edge leaving DONE.
    task automatic run8(input bit stall3, input bit pulse);
        begin_run8();
        for (int w = 0; w < 8; w++) begin
            q8.push_back({3'(w), wv[w]});
            send_word(wv[w], stall3 && w == 3, stall3, pulse && w == 2, stall3 && w == 3);
        end
        start8 = pulse;
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_after_run", 32'(if8.busy), 32'd0);
        chk("done_after_run", 32'(if8.done), 32'd0);
        chk("one_done", 32'(done_cnt8), 32'd1);
        chk("queue8_drained", 32'(q8.size()), 32'd0);
    endtask

    initial begin
        // Test 1: reset values and ignored serial data while idle.
        @(negedge clk);
        @(negedge clk);
        chk("rst_ram_in", 32'(if8.ram_in), 32'd0);
        chk("rst_ram_load", 32'(if8.ram_load), 32'd0);
        chk("rst_addr", 32'(if8.ram_address), 32'd0);
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_done", 32'(if8.done), 32'd0);
        chk("rst1_busy", 32'(if1.busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sin = 1'b1;
            sin_valid = 1'b1;
            @(negedge clk);
        end
        sin_valid = 1'b0;
        chk("idle_busy", 32'(if8.busy), 32'd0);
        chk("idle_load", 32'(if8.ram_load), 32'd0);

        // Test 2: single word into the one-word loader.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("single_busy", 32'(if1.busy), 32'd1);
        q1.push_back({3'd0, 16'hA5C3});
        send_word(16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_done", 32'(if1.done), 32'd1);
        chk("single_busy_in_done", 32'(if1.busy), 32'd0);
        @(negedge clk);
        chk("single_done_pulse", 32'(if1.done), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        chk("dut8_untouched", 32'(if8.busy), 32'd0);

        // Test 3: full run of walking ones, with RAM readback and exact latency.
        for (int i = 0; i < 8; i++) wv[i] = 16'(1 << i);
        run8(1'b0, 1'b0);
        chk("done_edge", 32'(done_edge8), 32'd136);
        for (int i = 0; i < 8; i++) chk("ram_readback", 32'(mem8[i]), 32'(wv[i]));

        // Test 4: random stalls inside word 3, junk bits during WRITE gaps.
        wv = '{16'h1234, 16'h5678, 16'h9ABC, 16'hBEEF, 16'hDEF0, 16'h0F0F, 16'hF00D, 16'h8001};
        run8(1'b1, 1'b0);
        chk("stall_ram3", 32'(mem8[3]), 32'hBEEF);

        // Test 5: start pulsed during SHIFT, WRITE and DONE is ignored.
        wv = '{16'hC001, 16'h0002, 16'h7FFF, 16'h4444, 16'hAAAA, 16'h5555, 16'h0000, 16'hFFFF};
        run8(1'b0, 1'b1);
        @(negedge clk);
        chk("start_in_done_ignored", 32'(if8.busy), 32'd0);

        // Test 6: asynchronous reset after 8 bits of word 2.
        begin_run8();
        q8.push_back({3'd0, 16'h1111});
        send_word(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
        q8.push_back({3'd1, 16'h2222});
        send_word(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 15; i >= 8; i--) begin
            sin = 1'(16'h3333 >> i);
            sin_valid = 1'b1;
            @(negedge clk);
        end
        chk("pre_reset_busy", 32'(if8.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_ram_in", 32'(if8.ram_in), 32'd0);
        chk("async_addr", 32'(if8.ram_address), 32'd0);
        chk("async_busy", 32'(if8.busy), 32'd0);
        chk("async_load", 32'(if8.ram_load), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        sin_valid = 1'b0;
        chk("abort_no_write2", 32'(q8.size()), 32'd0);
        chk("abort_idle", 32'(if8.busy), 32'd0);
        wv = '{16'hFACE, 16'h0101, 16'h2020, 16'h3003, 16'h4400, 16'h0550, 16'h6006, 16'h7777};
        run8(1'b0, 1'b0);
        chk("rerun_done_edge", 32'(done_edge8), 32'd136);
        for (int i = 0; i < 8; i++) chk("rerun_readback", 32'(mem8[i]), 32'(wv[i]));

        chk("queue1_final", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
